sprite_buffer: RTL and testbench

//  Pixel-memory responder for the rectangle/sprite drawing stage: answers rgb_address={y[5:0],x[5:0]}

---
 rtl/vga_pkg.sv | 23 ++
 rtl/sprite_buffer_if.sv | 27 ++
 rtl/sprite_ram.sv | 32 +++
 rtl/sprite_buffer.sv | 154 +++++++++++++++
 tb/tb_sprite_buffer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and types used by the sprite buffer and its loader.
package vga_pkg;

  localparam int SPRITE_XY_W   = 6;
  localparam int SPRITE_PIX_W  = 12;
  localparam int SPRITE_ADDR_W = 2 * SPRITE_XY_W;
  localparam int SPRITE_PIXELS = 4096;
  // Intended power-up content of the sprite RAM image; reset never rewrites memory.
  localparam logic [SPRITE_PIX_W-1:0] SPRITE_INIT_RGB = 12'h000;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } loader_state_t;

  // HI byte carries {R,G}; only the low nibble of the LO byte carries B.
  function automatic logic [SPRITE_PIX_W-1:0] join_pixel(input logic [7:0] red_green,
                                                         input logic [3:0] blue);
    return {red_green, blue};
  endfunction

endpackage

// File: rtl/sprite_buffer_if.sv
// Read port and byte-stream load port of the sprite buffer, bundled for the draw stage and host side.
interface sprite_buffer_if #(
  parameter int XY_W  = vga_pkg::SPRITE_XY_W,
  parameter int PIX_W = vga_pkg::SPRITE_PIX_W
);

  logic [2*XY_W-1:0] rgb_address;
  logic [PIX_W-1:0]  rgb_pixel;
  logic              load_start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              frame_tick;
  logic              load_busy;
  logic              load_done;

  modport slave (
    input  rgb_address, load_start, in_data, in_valid, frame_tick,
    output rgb_pixel, in_ready, load_busy, load_done
  );

  modport master (
    output rgb_address, load_start, in_data, in_valid, frame_tick,
    input  rgb_pixel, in_ready, load_busy, load_done
  );

endinterface

// File: rtl/sprite_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, read-first on collision.
module sprite_ram #(
  parameter int AW = 12,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sprite_buffer.sv
// Sprite pixel memory with a byte-stream loader. Define SPRITE_DOUBLE_BUFFER_EN for two banks
// swapped at frame_tick; otherwise a single bank whose writes are visible on the next read.
module sprite_buffer
  import vga_pkg::*;
#(
  parameter int XY_W  = SPRITE_XY_W,
  parameter int PIX_W = SPRITE_PIX_W
) (
  input logic            clk,
  input logic            rst,
  sprite_buffer_if.slave bus
);

  localparam int AW = 2 * XY_W;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  loader_state_t state, next_state;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    hi_byte;
  logic          load_done_q;
  logic          transfer;
  logic          stage_hi;
  logic          write_px;
  logic          clear_ptr;
  logic          finish;
  logic [PIX_W-1:0] wr_data;

  assign bus.in_ready  = (state != IDLE);
  assign bus.load_busy = (state != IDLE);
  assign bus.load_done = load_done_q;
  assign transfer      = bus.in_valid & bus.in_ready;
  assign wr_data       = join_pixel(hi_byte, bus.in_data[3:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      hi_byte     <= '0;
      load_done_q <= 1'b0;
    end else begin
      state       <= next_state;
      load_done_q <= finish;
      if (clear_ptr) begin
        wr_ptr <= '0;
      end else if (write_px) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (stage_hi) begin
        hi_byte <= bus.in_data;
      end
    end
  end

  // load_start overrides everything, including a byte offered in the same cycle.
  always_comb begin
    next_state = state;
    stage_hi   = 1'b0;
    write_px   = 1'b0;
    clear_ptr  = 1'b0;
    finish     = 1'b0;
    if (bus.load_start) begin
      next_state = HI;
      clear_ptr  = 1'b1;
    end else begin
      case (state)
        HI: begin
          if (transfer) begin
            next_state = LO;
            stage_hi   = 1'b1;
          end
        end
        LO: begin
          if (transfer) begin
            write_px = 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              next_state = IDLE;
              finish     = 1'b1;
            end else begin
              next_state = HI;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef SPRITE_DOUBLE_BUFFER_EN

  logic front;
  logic front_q;
  logic swap_pending;
  logic [PIX_W-1:0] rdata0;
  logic [PIX_W-1:0] rdata1;

  // front_q follows the bank that was read at the edge the current rgb_pixel was captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      front        <= 1'b0;
      front_q      <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      front_q <= front;
      if (bus.load_start) begin
        swap_pending <= 1'b0;
      end else if (bus.frame_tick && swap_pending) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (finish) begin
        swap_pending <= 1'b1;
      end
    end
  end

  sprite_ram #(.AW(AW), .DW(PIX_W)) u_ram0 (
    .clk   (clk),
    .rst   (rst),
    .we    (write_px & front),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (bus.rgb_address),
    .rdata (rdata0)
  );

  sprite_ram #(.AW(AW), .DW(PIX_W)) u_ram1 (
    .clk   (clk),
    .rst   (rst),
    .we    (write_px & ~front),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (bus.rgb_address),
    .rdata (rdata1)
  );

  assign bus.rgb_pixel = front_q ? rdata1 : rdata0;

`else

  logic unused_frame_tick;
  assign unused_frame_tick = bus.frame_tick;

  sprite_ram #(.AW(AW), .DW(PIX_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (write_px),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (bus.rgb_address),
    .rdata (bus.rgb_pixel)
  );

`endif

endmodule

// File: tb/tb_sprite_buffer.sv
// Directed, scoreboarded bench for sprite_buffer; follows SPRITE_DOUBLE_BUFFER_EN when defined.
module tb_sprite_buffer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;

  sprite_buffer_if bus ();

  sprite_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;
  int base_done  = 0;
  int tb_front   = 0;
  int tb_ptr     = 0;
  bit tb_pending = 1'b0;
  logic [11:0] model_mem [2][4096];
  logic [11:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.load_done === 1'b1) done_count++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  function automatic int write_bank();
`ifdef SPRITE_DOUBLE_BUFFER_EN
    return 1 - tb_front;
`else
    return tb_front;
`endif
  endfunction

  // One byte over valid/ready, with an occasional idle gap before it.
  task automatic applyStimulus(input logic [7:0] data, input bit ft);
    int waited;
    waited = 0;
    if ($urandom_range(0, 7) == 0) begin
      bus.in_valid = 1'b0;
      tick;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    while (bus.in_ready !== 1'b1 && waited < 16) begin
      tick;
      waited++;
    end
    if (waited >= 16) checkOutput("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.frame_tick = ft;
    tick;
    bus.in_valid   = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic loadPixel(input logic [11:0] pix, input bit ft_on_last);
    applyStimulus(pix[11:4], 1'b0);
    applyStimulus({4'($urandom), pix[3:0]}, ft_on_last && (tb_ptr == 4095));
    model_mem[write_bank()][tb_ptr] = pix;
    if (tb_ptr == 4095) begin
      tb_ptr     = 0;
      tb_pending = 1'b1;
    end else begin
      tb_ptr++;
    end
  endtask

  task automatic loadAll(input logic [11:0] value, input bit pattern, input bit ft_on_last);
    for (int n = 0; n < 4096; n++) begin
      loadPixel(pattern ? 12'(n) : value, ft_on_last);
    end
  endtask

  task automatic startLoad;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    tb_ptr     = 0;
    tb_pending = 1'b0;
  endtask

  task automatic frameTick;
    bus.frame_tick = 1'b1;
    tick;
    bus.frame_tick = 1'b0;
`ifdef SPRITE_DOUBLE_BUFFER_EN
    if (tb_pending) begin
      tb_front   = 1 - tb_front;
      tb_pending = 1'b0;
    end
`endif
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr);
    bus.rgb_address = addr;
    exp_q.push_back(model_mem[tb_front][addr]);
    tick;
    checkOutput(tag, {20'd0, bus.rgb_pixel}, {20'd0, exp_q.pop_front()});
  endtask

  initial begin
    rst             = 1'b0;
    bus.rgb_address = '0;
    bus.load_start  = 1'b0;
    bus.in_data     = 8'h55;
    bus.in_valid    = 1'b1;
    bus.frame_tick  = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4096; a++) model_mem[b][a] = SPRITE_INIT_RGB;

    // Reset with a byte on offer
    repeat (3) tick;
    checkOutput("reset_pixel", {20'd0, bus.rgb_pixel}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.load_busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.load_done}, 32'd0);
    rst = 1'b1;
    tick;
    checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("idle_busy", {31'd0, bus.load_busy}, 32'd0);
    bus.in_valid = 1'b0;

    // Full load of {A5,0C}
    startLoad;
    checkOutput("start_busy", {31'd0, bus.load_busy}, 32'd1);
    checkOutput("start_ready", {31'd0, bus.in_ready}, 32'd1);
    base_done = done_count;
    loadAll(12'hA5C, 1'b0, 1'b0);
    checkOutput("full_done_pulse", {31'd0, bus.load_done}, 32'd1);
    checkOutput("full_busy_end", {31'd0, bus.load_busy}, 32'd0);
    tick;
    checkOutput("full_done_low", {31'd0, bus.load_done}, 32'd0);
    checkOutput("full_done_count", done_count - base_done, 32'd1);
`ifdef SPRITE_DOUBLE_BUFFER_EN
    frameTick;
`endif
    readCheck("full_000", 12'h000);
    readCheck("full_fff", 12'hFFF);

    // Pixel n holds n, checks {y,x} addressing and 1-cycle latency
    startLoad;
    loadAll(12'h000, 1'b1, 1'b0);
`ifdef SPRITE_DOUBLE_BUFFER_EN
    frameTick;
`endif
    readCheck("pat_abc", 12'hABC);
    bus.rgb_address = {6'd3, 6'd5};
    #1;
    checkOutput("pat_latency_hold", {20'd0, bus.rgb_pixel}, 32'hABC);
    readCheck("pat_y3_x5", {6'd3, 6'd5});
    for (int i = 0; i < 6; i++) readCheck("pat_random", 12'($urandom_range(0, 4095)));

    // Abort mid-load, restart with a byte offered in the same cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick;
    checkOutput("idle_no_accept", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    startLoad;
    base_done = done_count;
    for (int i = 0; i < 100; i++) loadPixel(12'h777, 1'b0);
    applyStimulus(8'h77, 1'b0);
    bus.load_start = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'hEE;
    tick;
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    tb_ptr     = 0;
    tb_pending = 1'b0;
    checkOutput("abort_busy", {31'd0, bus.load_busy}, 32'd1);
    checkOutput("abort_no_done", done_count - base_done, 32'd0);
    loadAll(12'h123, 1'b0, 1'b0);
    tick;
    checkOutput("abort_done_count", done_count - base_done, 32'd1);
`ifdef SPRITE_DOUBLE_BUFFER_EN
    frameTick;
`endif
    readCheck("abort_000", 12'h000);
    readCheck("abort_050", 12'd50);
    readCheck("abort_099", 12'd99);
    readCheck("abort_100", 12'd100);
    readCheck("abort_fff", 12'hFFF);

`ifdef SPRITE_DOUBLE_BUFFER_EN
    // Completed load stays hidden until frame_tick
    startLoad;
    loadAll(12'h0F0, 1'b0, 1'b0);
    repeat (3) tick;
    readCheck("db_old_000", 12'h000);
    readCheck("db_old_abc", 12'hABC);
    frameTick;
    readCheck("db_new_000", 12'h000);
    readCheck("db_new_abc", 12'hABC);
    // frame_tick coinciding with completion defers the swap
    startLoad;
    loadAll(12'h456, 1'b0, 1'b1);
    checkOutput("db_same_done", {31'd0, bus.load_done}, 32'd1);
    readCheck("db_deferred_010", 12'h010);
    readCheck("db_deferred_fff", 12'hFFF);
    frameTick;
    readCheck("db_swapped_010", 12'h010);
    readCheck("db_swapped_fff", 12'hFFF);
`else
    // Write and read of the same address in one cycle returns the old pixel
    startLoad;
    for (int i = 0; i < 16; i++) loadPixel(12'hB00 + 12'(i), 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("collide_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.rgb_address = 12'h010;
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'h0F;
    exp_q.push_back(model_mem[tb_front][12'h010]);
    tick;
    bus.in_valid = 1'b0;
    checkOutput("collide_old", {20'd0, bus.rgb_pixel}, {20'd0, exp_q.pop_front()});
    model_mem[write_bank()][12'h010] = 12'hFFF;
    tb_ptr++;
    readCheck("collide_new", 12'h010);
    readCheck("collide_neighbour", 12'h00F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
